dsp_mac_pipe: RTL

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe_pkg.sv | 17 +
 rtl/dsp_post_adder.sv | 51 +++++
 rtl/dsp_mac_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pipe_pkg.sv
// dsp_mac_pipe_pkg
// Shared constants for the pre-adder / multiplier / post-adder MAC pipeline.
//   PIPE_LATENCY : enabled clock edges from sampling a beat to seeing it on P
//   OP_*         : bit positions inside the 3-bit opmode field
package dsp_mac_pipe_pkg;

  localparam int PIPE_LATENCY = 4;
  localparam int OPMODE_W     = 3;

  // opmode[OP_PRE_SUB]  : 1 -> D-B, 0 -> D+B
  // opmode[OP_POST_SUB] : 1 -> Z-M, 0 -> Z+M
  // opmode[OP_ACC]      : 1 -> Z=P, 0 -> Z=C
  localparam int OP_PRE_SUB  = 0;
  localparam int OP_POST_SUB = 1;
  localparam int OP_ACC      = 2;

endpackage

// File: rtl/dsp_post_adder.sv
// dsp_post_adder
// Combinational post-adder for the final MAC stage: Z +/- M evaluated one bit
// wider than P so overflow can be detected, then either wrapped or clamped.
// Ports:
//   z_i   : P_WIDTH signed, accumulator / C operand
//   m_i   : P_WIDTH signed, sign-extended product
//   sub_i : 1 -> Z-M, 0 -> Z+M
//   p_o   : P_WIDTH signed result (wrapped or saturated)
//   ovf_o : result did not fit in P_WIDTH bits
module dsp_post_adder
  import dsp_mac_pipe_pkg::*;
#(
  parameter int P_WIDTH  = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic signed [P_WIDTH-1:0] z_i,
  input  logic signed [P_WIDTH-1:0] m_i,
  input  logic                      sub_i,
  output logic signed [P_WIDTH-1:0] p_o,
  output logic                      ovf_o
);

  localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

  logic [P_WIDTH:0] z_ext;
  logic [P_WIDTH:0] m_ext;
  logic [P_WIDTH:0] sum;

  assign z_ext = {z_i[P_WIDTH-1], z_i};
  assign m_ext = {m_i[P_WIDTH-1], m_i};
  assign sum   = sub_i ? (z_ext - m_ext) : (z_ext + m_ext);

  // The extra top bit is the true sign; disagreement with the P sign bit
  // means the exact result is outside the P_WIDTH range.
  assign ovf_o = sum[P_WIDTH] ^ sum[P_WIDTH-1];

  generate
    if (SATURATE) begin : g_sat
      always_comb begin
        p_o = sum[P_WIDTH-1:0];
        if (ovf_o) begin
          p_o = sum[P_WIDTH] ? P_MIN : P_MAX;
        end
      end
    end else begin : g_wrap
      assign p_o = sum[P_WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe
// Four-stage pre-add / multiply / post-add MAC: P = Z +/- A*(D +/- B),
// with Z either C or the current P (accumulate). Opmode and valid travel
// with their beat, so every beat carries its own mode.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   ce         : clock enable for every register (valid bits included)
//   in_valid   : current A/B/C/D/opmode beat is valid
//   opmode     : [0] pre_sub, [1] post_sub, [2] acc
//   A          : A_WIDTH signed multiplicand
//   B, D       : BD_WIDTH signed pre-adder operands
//   C          : P_WIDTH signed post-adder operand
//   P          : P_WIDTH signed registered result
//   out_valid  : P holds the result of a valid beat
//   ovf        : post-adder overflow on the beat shown on P
module dsp_mac_pipe
  import dsp_mac_pipe_pkg::*;
#(
  parameter int A_WIDTH  = 18,
  parameter int BD_WIDTH = 18,
  parameter int P_WIDTH  = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [OPMODE_W-1:0]        opmode,
  input  logic signed [A_WIDTH-1:0]  A,
  input  logic signed [BD_WIDTH-1:0] B,
  input  logic signed [BD_WIDTH-1:0] D,
  input  logic signed [P_WIDTH-1:0]  C,
  output logic signed [P_WIDTH-1:0]  P,
  output logic                       out_valid,
  output logic                       ovf
);

  localparam int PA_W = BD_WIDTH + 1;
  localparam int M_W  = A_WIDTH + BD_WIDTH + 1;

  generate
    if (P_WIDTH < M_W) begin : g_width_check
      $error("dsp_mac_pipe: P_WIDTH must be at least A_WIDTH+BD_WIDTH+1");
    end
  endgenerate

  // Stage 1: input registers
  logic signed [A_WIDTH-1:0]  a_s1_q;
  logic signed [BD_WIDTH-1:0] b_s1_q;
  logic signed [BD_WIDTH-1:0] d_s1_q;
  logic signed [P_WIDTH-1:0]  c_s1_q;
  logic [OPMODE_W-1:0]        op_s1_q;
  logic                       v_s1_q;

  // Stage 2: pre-adder result
  logic signed [A_WIDTH-1:0]  a_s2_q;
  logic signed [PA_W-1:0]     pa_s2_q;
  logic signed [P_WIDTH-1:0]  c_s2_q;
  logic [OPMODE_W-1:0]        op_s2_q;
  logic                       v_s2_q;
  logic signed [PA_W-1:0]     pa_d;

  // Stage 3: product
  logic signed [M_W-1:0]      m_s3_q;
  logic signed [P_WIDTH-1:0]  c_s3_q;
  logic [OPMODE_W-1:0]        op_s3_q;
  logic                       v_s3_q;
  logic signed [M_W-1:0]      m_d;

  // Stage 4: result registers
  logic signed [P_WIDTH-1:0]  p_q;
  logic                       ovf_q;
  logic                       out_valid_q;
  logic signed [P_WIDTH-1:0]  p_d;
  logic                       ovf_d;
  logic signed [P_WIDTH-1:0]  z_d;
  logic signed [P_WIDTH-1:0]  m_ext_d;

  // Exact pre-add: both operands sign-extended by one bit first.
  assign pa_d = op_s1_q[OP_PRE_SUB] ? (PA_W'(d_s1_q) - PA_W'(b_s1_q))
                                    : (PA_W'(d_s1_q) + PA_W'(b_s1_q));

  // Exact product: A*PA always fits in M_W bits.
  assign m_d = M_W'(a_s2_q) * M_W'(pa_s2_q);

  // Accumulate feeds back the live P register. Back-to-back accumulating
  // beats see the previous beat's result because P updates every edge
  // that stage 4 holds a valid beat.
  assign z_d     = op_s3_q[OP_ACC] ? p_q : c_s3_q;
  assign m_ext_d = P_WIDTH'(m_s3_q);

  dsp_post_adder #(
    .P_WIDTH  (P_WIDTH),
    .SATURATE (SATURATE)
  ) u_post_adder (
    .z_i   (z_d),
    .m_i   (m_ext_d),
    .sub_i (op_s3_q[OP_POST_SUB]),
    .p_o   (p_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1_q      <= '0;
      b_s1_q      <= '0;
      d_s1_q      <= '0;
      c_s1_q      <= '0;
      op_s1_q     <= '0;
      v_s1_q      <= 1'b0;
      a_s2_q      <= '0;
      pa_s2_q     <= '0;
      c_s2_q      <= '0;
      op_s2_q     <= '0;
      v_s2_q      <= 1'b0;
      m_s3_q      <= '0;
      c_s3_q      <= '0;
      op_s3_q     <= '0;
      v_s3_q      <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      a_s1_q  <= A;
      b_s1_q  <= B;
      d_s1_q  <= D;
      c_s1_q  <= C;
      op_s1_q <= opmode;
      v_s1_q  <= in_valid;

      a_s2_q  <= a_s1_q;
      pa_s2_q <= pa_d;
      c_s2_q  <= c_s1_q;
      op_s2_q <= op_s1_q;
      v_s2_q  <= v_s1_q;

      m_s3_q  <= m_d;
      c_s3_q  <= c_s2_q;
      op_s3_q <= op_s2_q;
      v_s3_q  <= v_s2_q;

      // Bubbles leave P and ovf untouched so an accumulation in progress
      // resumes from the same value after the gap.
      if (v_s3_q) begin
        p_q         <= p_d;
        ovf_q       <= ovf_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign P         = p_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule
